// File: rtl/drive_controller_if.sv
// Sensor, tone, encoder and H-bridge signal bundle
// for the line-following robot drive core.
interface drive_controller_if;
  logic [3:0] dir;
  logic       col_detect;
  logic       td_en;
  logic [1:0] td_dir;
  logic       shaft_pulse_l;
  logic       shaft_pulse_r;
  logic       hb_en_a;
  logic       hb_en_b;
  logic       hb_in1;
  logic       hb_in2;
  logic       hb_in3;
  logic       hb_in4;
  logic [2:0] state;
  logic       busy;

  modport master (
    output dir, col_detect, td_en, td_dir,
    output shaft_pulse_l, shaft_pulse_r,
    input  hb_en_a, hb_en_b,
    input  hb_in1, hb_in2, hb_in3, hb_in4,
    input  state, busy
  );

  modport slave (
    input  dir, col_detect, td_en, td_dir,
    input  shaft_pulse_l, shaft_pulse_r,
    output hb_en_a, hb_en_b,
    output hb_in1, hb_in2, hb_in3, hb_in4,
    output state, busy
  );
endinterface

// File: rtl/drive_controller.sv
// Drive core: PWM, encoder-counted pivots, reverse
// and collision resume for the dual H-bridge.
module drive_controller #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int PWM_HZ      = 80,
  parameter int FULL_PCT    = 80,
  parameter int VEER_PCT    = 40,
  parameter int MAX_PCT     = 80,
  parameter int TURN_PULSES = 20,
  parameter int CNT_W       = 20,
  parameter int PULSE_W     = 8
) (
  input logic clk,
  input logic rst,
  drive_controller_if.slave bus
);

  typedef enum logic [2:0] {
    FORWARD   = 3'd0,
    COLLISION = 3'd1,
    JUNCTION  = 3'd2,
    CROSS     = 3'd3,
    TURN_L    = 3'd4,
    TURN_R    = 3'd5,
    REVERSE   = 3'd6
  } state_t;

  localparam int PWM_PERIOD = CLK_HZ / PWM_HZ;
  localparam int FULL_C =
    (FULL_PCT > MAX_PCT) ? MAX_PCT : FULL_PCT;
  localparam int VEER_C =
    (VEER_PCT > MAX_PCT) ? MAX_PCT : VEER_PCT;
  localparam int FULL_TH = PWM_PERIOD * FULL_C / 100;
  localparam int VEER_TH = PWM_PERIOD * VEER_C / 100;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] FULL_W = CNT_W'(FULL_TH);
  localparam logic [CNT_W-1:0] VEER_W = CNT_W'(VEER_TH);
  localparam logic [PULSE_W-1:0] P90 =
    PULSE_W'(TURN_PULSES);
  localparam logic [PULSE_W-1:0] P180 =
    PULSE_W'(2 * TURN_PULSES);

  logic [CNT_W-1:0]   cnt;
  logic [2:0]         syncL;
  logic [2:0]         syncR;
  logic [PULSE_W-1:0] pcnt;
  state_t             st;
  state_t             retSt;
  logic [5:0]         hb;

  logic pf;
  logic pv;
  logic edgeL;
  logic edgeR;

  assign pf = (cnt < FULL_W);
  assign pv = (cnt < VEER_W);

  // bits [0],[1] synchronise, bit [2] holds the previous sample
  assign edgeL = syncL[1] & ~syncL[2];
  assign edgeR = syncR[1] & ~syncR[2];

  logic [5:0] patFwd;
  logic [5:0] patVl;
  logic [5:0] patVr;
  logic [5:0] patPl;
  logic [5:0] patPr;

  assign patFwd = {pf, pf, 4'b0110};
  assign patVl  = {pv, pf, 4'b0110};
  assign patVr  = {pf, pv, 4'b0110};
  assign patPl  = {pf, pf, 4'b1010};
  assign patPr  = {pf, pf, 4'b0101};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncL <= '0;
      syncR <= '0;
    end else begin
      syncL <= {syncL[1:0], bus.shaft_pulse_l};
      syncR <= {syncR[1:0], bus.shaft_pulse_r};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= FORWARD;
      retSt <= FORWARD;
      pcnt  <= '0;
      hb    <= '0;
    end else if (bus.col_detect && st != COLLISION) begin
      retSt <= st;
      st    <= COLLISION;
      hb    <= '0;
    end else begin
      unique case (st)
        FORWARD: begin
          unique case (bus.dir)
            4'b0101: hb <= patVl;
            4'b1001: hb <= patVr;
            4'b0111: hb <= patPl;
            4'b1011: hb <= patPr;
            4'b1111: begin
              hb <= '0;
              st <= JUNCTION;
            end
            4'b1100,
            4'b1101,
            4'b1110: hb <= '0;
            default: hb <= patFwd;
          endcase
        end
        COLLISION: begin
          hb <= '0;
          if (!bus.col_detect) st <= retSt;
        end
        JUNCTION: begin
          hb <= '0;
          if (bus.td_en) begin
            unique case (bus.td_dir)
              2'b00: st <= CROSS;
              2'b01: begin
                st   <= TURN_L;
                pcnt <= '0;
              end
              2'b10: begin
                st   <= TURN_R;
                pcnt <= '0;
              end
              default: begin
                st   <= REVERSE;
                pcnt <= '0;
              end
            endcase
          end
        end
        CROSS: begin
          hb <= patFwd;
          if (bus.dir != 4'b1111) st <= FORWARD;
        end
        TURN_L: begin
          hb <= patPl;
          if (pcnt == P90) begin
            pcnt <= '0;
            st   <= FORWARD;
          end else if (edgeR) begin
            pcnt <= pcnt + 1'b1;
          end
        end
        TURN_R: begin
          hb <= patPr;
          if (pcnt == P90) begin
            pcnt <= '0;
            st   <= FORWARD;
          end else if (edgeL) begin
            pcnt <= pcnt + 1'b1;
          end
        end
        REVERSE: begin
          hb <= patPr;
          if (pcnt == P180) begin
            pcnt <= '0;
            st   <= FORWARD;
          end else if (edgeL) begin
            pcnt <= pcnt + 1'b1;
          end
        end
        default: begin
          hb <= '0;
          st <= FORWARD;
        end
      endcase
    end
  end

  assign bus.hb_en_a = hb[5];
  assign bus.hb_en_b = hb[4];
  assign bus.hb_in1  = hb[3];
  assign bus.hb_in2  = hb[2];
  assign bus.hb_in3  = hb[1];
  assign bus.hb_in4  = hb[0];
  assign bus.state   = st;
  assign bus.busy    = (st == TURN_L) ||
                       (st == TURN_R) ||
                       (st == REVERSE);

endmodule

// File: tb/tb_drive_controller.sv
// Directed bench for drive_controller: PWM clamp,
// junction turns, collision resume, reverse, cross, reset.
module tb_drive_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  drive_controller_if bus();

  drive_controller #(
    .CLK_HZ(1000),
    .PWM_HZ(10),
    .FULL_PCT(90),
    .VEER_PCT(40),
    .MAX_PCT(80),
    .TURN_PULSES(3),
    .CNT_W(20),
    .PULSE_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  wire [5:0] hbAll = {bus.hb_en_a, bus.hb_en_b,
                      bus.hb_in1, bus.hb_in2,
                      bus.hb_in3, bus.hb_in4};
  wire [3:0] ins = hbAll[3:0];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit left);
    if (left) bus.shaft_pulse_l = 1'b1;
    else      bus.shaft_pulse_r = 1'b1;
    tick(3);
    bus.shaft_pulse_l = 1'b0;
    bus.shaft_pulse_r = 1'b0;
    tick(3);
  endtask

  task automatic enterJunction(input logic [1:0] d);
    bus.dir = 4'b1111;
    tick(1);
    bus.td_dir = d;
    bus.td_en  = 1'b1;
    bus.dir    = 4'b0000;
    tick(1);
    bus.td_en  = 1'b0;
  endtask

  task automatic test_reset();
    bus.dir = 4'b0000;
    bus.col_detect = 1'b0;
    bus.td_en = 1'b0;
    bus.td_dir = 2'b00;
    bus.shaft_pulse_l = 1'b0;
    bus.shaft_pulse_r = 1'b0;
    rst = 1'b1;
    tick(2);
    checks++;
    if (hbAll !== 6'b0) begin
      errors++;
      $display("FAIL reset_hb: got %b want 000000", hbAll);
    end
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0",
               bus.state);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (hbAll !== 6'b110110) begin
      errors++;
      $display("FAIL first_pwm: got %b want 110110", hbAll);
    end
  endtask

  task automatic test_pwm_clamp();
    int a = 0;
    int b = 0;
    int bad = 0;
    bus.dir = 4'b0101;
    tick(5);
    for (int i = 0; i < 100; i++) begin
      a += int'(bus.hb_en_a);
      b += int'(bus.hb_en_b);
      if (ins !== 4'b0110) bad++;
      tick(1);
    end
    tick(195);
    checks++;
    if (a != 40) begin
      errors++;
      $display("FAIL veer_duty: got %0d want 40", a);
    end
    checks++;
    if (b != 80) begin
      errors++;
      $display("FAIL full_clamp: got %0d want 80", b);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL veer_ins: got %0d bad want 0", bad);
    end
    bus.dir = 4'b0000;
    tick(2);
  endtask

  task automatic test_junction_left();
    bus.dir = 4'b1111;
    tick(1);
    checks++;
    if (bus.state !== 3'd2 || hbAll !== 6'b0) begin
      errors++;
      $display("FAIL junc_enter: got st=%0d hb=%b want 2/0",
               bus.state, hbAll);
    end
    bus.dir = 4'b0000;
    tick(50);
    checks++;
    if (bus.state !== 3'd2 || hbAll !== 6'b0) begin
      errors++;
      $display("FAIL junc_hold: got st=%0d hb=%b want 2/0",
               bus.state, hbAll);
    end
    bus.td_dir = 2'b01;
    bus.td_en = 1'b1;
    tick(1);
    bus.td_en = 1'b0;
    checks++;
    if (bus.state !== 3'd4 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL turnl_enter: got st=%0d busy=%b want 4/1",
               bus.state, bus.busy);
    end
    tick(1);
    checks++;
    if (ins !== 4'b1010) begin
      errors++;
      $display("FAIL pivot_l: got %b want 1010", ins);
    end
    pulse(1'b0);
    pulse(1'b0);
    bus.shaft_pulse_r = 1'b1;
    tick(3);
    checks++;
    if (bus.state !== 3'd4) begin
      errors++;
      $display("FAIL turnl_early: got %0d want 4", bus.state);
    end
    tick(1);
    checks++;
    if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL turnl_done: got st=%0d busy=%b want 0/0",
               bus.state, bus.busy);
    end
    bus.shaft_pulse_r = 1'b0;
    tick(3);
  endtask

  task automatic test_collision();
    enterJunction(2'b10);
    checks++;
    if (bus.state !== 3'd5) begin
      errors++;
      $display("FAIL turnr_enter: got %0d want 5", bus.state);
    end
    pulse(1'b1);
    bus.col_detect = 1'b1;
    tick(1);
    checks++;
    if (bus.state !== 3'd1 || hbAll !== 6'b0) begin
      errors++;
      $display("FAIL col_enter: got st=%0d hb=%b want 1/0",
               bus.state, hbAll);
    end
    pulse(1'b1);
    tick(2);
    bus.col_detect = 1'b0;
    tick(1);
    checks++;
    if (bus.state !== 3'd5) begin
      errors++;
      $display("FAIL col_resume: got %0d want 5", bus.state);
    end
    tick(1);
    checks++;
    if (ins !== 4'b0101) begin
      errors++;
      $display("FAIL pivot_r: got %b want 0101", ins);
    end
    pulse(1'b1);
    bus.shaft_pulse_l = 1'b1;
    tick(3);
    checks++;
    if (bus.state !== 3'd5) begin
      errors++;
      $display("FAIL col_count: got %0d want 5", bus.state);
    end
    tick(1);
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL turnr_done: got %0d want 0", bus.state);
    end
    bus.shaft_pulse_l = 1'b0;
    tick(3);
  endtask

  task automatic test_reverse();
    enterJunction(2'b11);
    checks++;
    if (bus.state !== 3'd6 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rev_enter: got st=%0d busy=%b want 6/1",
               bus.state, bus.busy);
    end
    tick(1);
    checks++;
    if (ins !== 4'b0101) begin
      errors++;
      $display("FAIL rev_ins: got %b want 0101", ins);
    end
    pulse(1'b0);
    pulse(1'b0);
    for (int i = 0; i < 5; i++) pulse(1'b1);
    checks++;
    if (bus.state !== 3'd6) begin
      errors++;
      $display("FAIL rev_early: got %0d want 6", bus.state);
    end
    bus.shaft_pulse_l = 1'b1;
    tick(3);
    checks++;
    if (bus.state !== 3'd6) begin
      errors++;
      $display("FAIL rev_last: got %0d want 6", bus.state);
    end
    tick(1);
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL rev_done: got %0d want 0", bus.state);
    end
    bus.shaft_pulse_l = 1'b0;
    tick(3);
  endtask

  task automatic test_cross();
    bus.dir = 4'b1111;
    tick(1);
    bus.td_dir = 2'b00;
    bus.td_en = 1'b1;
    tick(1);
    bus.td_en = 1'b0;
    checks++;
    if (bus.state !== 3'd3) begin
      errors++;
      $display("FAIL cross_enter: got %0d want 3", bus.state);
    end
    tick(1);
    checks++;
    if (ins !== 4'b0110 || bus.state !== 3'd3) begin
      errors++;
      $display("FAIL cross_drive: got ins=%b st=%0d want 0110/3",
               ins, bus.state);
    end
    bus.dir = 4'b0000;
    tick(1);
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL cross_exit: got %0d want 0", bus.state);
    end
    tick(2);
  endtask

  task automatic test_async_reset();
    enterJunction(2'b11);
    pulse(1'b1);
    checks++;
    if (ins !== 4'b0101 || bus.state !== 3'd6) begin
      errors++;
      $display("FAIL pre_rst: got ins=%b st=%0d want 0101/6",
               ins, bus.state);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (hbAll !== 6'b0 || bus.state !== 3'd0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: got hb=%b st=%0d want 0/0",
               hbAll, bus.state);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    enterJunction(2'b01);
    pulse(1'b0);
    pulse(1'b0);
    checks++;
    if (bus.state !== 3'd4) begin
      errors++;
      $display("FAIL post_rst_cnt: got %0d want 4", bus.state);
    end
    bus.shaft_pulse_r = 1'b1;
    tick(4);
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL post_rst_done: got %0d want 0",
               bus.state);
    end
    bus.shaft_pulse_r = 1'b0;
    tick(3);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pwm_clamp();
    test_junction_left();
    test_collision();
    test_reverse();
    test_cross();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
